// File: rtl/texture_quad_buffer.sv
// texture_quad_buffer: single-texture store filled over AXI-Stream,
// read through four independent fixed-latency texel ports.
module texture_quad_buffer #(
  parameter int PIXEL_WIDTH  = 16,
  parameter int STREAM_WIDTH = 64,
  parameter int READ_DELAY   = 1,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                    aclk,
  input  logic                    resetn,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [STREAM_WIDTH-1:0] s_axis_tdata,
  output logic                    uploadDone,
  output logic                    uploadOverflow,
  input  logic [ADDR_WIDTH-1:0]   texelAddr00,
  input  logic [ADDR_WIDTH-1:0]   texelAddr01,
  input  logic [ADDR_WIDTH-1:0]   texelAddr10,
  input  logic [ADDR_WIDTH-1:0]   texelAddr11,
  output logic [PIXEL_WIDTH-1:0]  texelOutput00,
  output logic [PIXEL_WIDTH-1:0]  texelOutput01,
  output logic [PIXEL_WIDTH-1:0]  texelOutput10,
  output logic [PIXEL_WIDTH-1:0]  texelOutput11
);

  localparam int PPB   = STREAM_WIDTH / PIXEL_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = 4;

  typedef enum logic {
    ST_ACCEPT,
    ST_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_tready;
  logic                  r_done;
  logic                  r_ovf;
  logic                  w_ovf_nxt;
  logic [ADDR_WIDTH:0]   r_wrptr;
  logic [ADDR_WIDTH:0]   w_wrptr_nxt;
  logic [ADDR_WIDTH-1:0] w_base;
  logic                  w_acc;
  logic                  w_last;
  logic                  w_full;
  logic                  w_wr;

  logic [ADDR_WIDTH-1:0]  w_addr [NB];
  logic [PIXEL_WIDTH-1:0] w_out  [NB];

  assign w_acc  = s_axis_tvalid && r_tready;
  assign w_last = w_acc && s_axis_tlast;
  assign w_full = r_wrptr[ADDR_WIDTH];
  assign w_wr   = w_acc && !w_full;
  assign w_base = r_wrptr[ADDR_WIDTH-1:0];

  assign s_axis_tready  = r_tready;
  assign uploadDone     = r_done;
  assign uploadOverflow = r_ovf;

  assign w_addr[0] = texelAddr00;
  assign w_addr[1] = texelAddr01;
  assign w_addr[2] = texelAddr10;
  assign w_addr[3] = texelAddr11;

  assign texelOutput00 = w_out[0];
  assign texelOutput01 = w_out[1];
  assign texelOutput10 = w_out[2];
  assign texelOutput11 = w_out[3];

  // Next-state for the upload FSM, write pointer and overflow flag.
  // The pointer holds once full so a long overflow never wraps to 0.
  always_comb begin
    w_state_nxt = r_state;
    w_wrptr_nxt = r_wrptr;
    w_ovf_nxt   = r_ovf;
    unique case (r_state)
      ST_ACCEPT: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_ACCEPT;
    endcase
    if (w_wr)
      w_wrptr_nxt = r_wrptr + (ADDR_WIDTH+1)'(PPB);
    if (w_acc && w_full)
      w_ovf_nxt = 1'b1;
    if (w_last) begin
      w_wrptr_nxt = '0;
      w_ovf_nxt   = 1'b0;
    end
  end

  // Control registers; tready and done are registered decodes of state.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_ACCEPT;
      r_tready <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_wrptr  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_tready <= (w_state_nxt == ST_ACCEPT);
      r_done   <= (w_state_nxt == ST_DONE);
      r_ovf    <= w_ovf_nxt;
      r_wrptr  <= w_wrptr_nxt;
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_bank
    logic [PIXEL_WIDTH-1:0] r_mem  [DEPTH];
    logic [PIXEL_WIDTH-1:0] r_pipe [READ_DELAY];

    // Every bank takes the same beat so all four hold one image.
    always_ff @(posedge aclk) begin
      if (w_wr) begin
        for (int k = 0; k < PPB; k++)
          r_mem[w_base + ADDR_WIDTH'(k)] <=
            s_axis_tdata[k*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
    end

    // Read-first sample, then a reset-cleared delay line to the port.
    always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
        for (int s = 0; s < READ_DELAY; s++)
          r_pipe[s] <= '0;
      end else begin
        r_pipe[0] <= r_mem[w_addr[g]];
        for (int s = 1; s < READ_DELAY; s++)
          r_pipe[s] <= r_pipe[s-1];
      end
    end

    assign w_out[g] = r_pipe[READ_DELAY-1];
  end

endmodule

// File: tb/tb_texture_quad_buffer.sv
// tb_texture_quad_buffer: directed upload/read checks on two builds
// (READ_DELAY 1 and 3) sharing one stimulus, 16-texel capacity.
module tb_texture_quad_buffer;

  localparam int PW = 16;
  localparam int SW = 64;
  localparam int AW = 4;

  logic          aclk = 1'b0;
  logic          resetn;
  logic          tvalid;
  logic          tlast;
  logic [SW-1:0] tdata;
  logic [AW-1:0] a [4];

  logic          tready1, done1, ovf1;
  logic          tready3, done3, ovf3;
  logic [PW-1:0] o1 [4];
  logic [PW-1:0] o3 [4];

  logic [PW-1:0] mm [16];
  bit            mv [16];
  bit [4:0]      mptr;
  bit            mready, mdone, movf;
  logic [PW-1:0] hv  [4][3];
  bit            hok [4][3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 aclk = ~aclk;

  texture_quad_buffer #(
    .PIXEL_WIDTH(PW), .STREAM_WIDTH(SW),
    .READ_DELAY(1), .ADDR_WIDTH(AW)
  ) u_d1 (
    .aclk(aclk), .resetn(resetn),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready1),
    .s_axis_tlast(tlast), .s_axis_tdata(tdata),
    .uploadDone(done1), .uploadOverflow(ovf1),
    .texelAddr00(a[0]), .texelAddr01(a[1]),
    .texelAddr10(a[2]), .texelAddr11(a[3]),
    .texelOutput00(o1[0]), .texelOutput01(o1[1]),
    .texelOutput10(o1[2]), .texelOutput11(o1[3])
  );

  texture_quad_buffer #(
    .PIXEL_WIDTH(PW), .STREAM_WIDTH(SW),
    .READ_DELAY(3), .ADDR_WIDTH(AW)
  ) u_d3 (
    .aclk(aclk), .resetn(resetn),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready3),
    .s_axis_tlast(tlast), .s_axis_tdata(tdata),
    .uploadDone(done3), .uploadOverflow(ovf3),
    .texelAddr00(a[0]), .texelAddr01(a[1]),
    .texelAddr10(a[2]), .texelAddr11(a[3]),
    .texelOutput00(o3[0]), .texelOutput01(o3[1]),
    .texelOutput10(o3[2]), .texelOutput11(o3[3])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [SW-1:0] pk(input int v0, input int v1,
                                       input int v2, input int v3);
    return {16'(v3), 16'(v2), 16'(v1), 16'(v0)};
  endfunction

  task automatic model_reset();
    mptr   = '0;
    mready = 1'b0;
    mdone  = 1'b0;
    movf   = 1'b0;
    for (int p = 0; p < 4; p++)
      for (int s = 0; s < 3; s++) begin
        hv[p][s]  = '0;
        hok[p][s] = 1'b1;
      end
  endtask

  task automatic check_all();
    chk("tready1", 32'(tready1), 32'(mready));
    chk("tready3", 32'(tready3), 32'(mready));
    chk("done1", 32'(done1), 32'(mdone));
    chk("done3", 32'(done3), 32'(mdone));
    chk("ovf1", 32'(ovf1), 32'(movf));
    chk("ovf3", 32'(ovf3), 32'(movf));
    for (int p = 0; p < 4; p++) begin
      if (hok[p][0])
        chk($sformatf("rd1_p%0d", p), 32'(o1[p]), 32'(hv[p][0]));
      if (hok[p][2])
        chk($sformatf("rd3_p%0d", p), 32'(o3[p]), 32'(hv[p][2]));
    end
  endtask

  task automatic tick();
    logic [PW-1:0] rv [4];
    bit            rok [4];
    bit            acc;
    for (int p = 0; p < 4; p++) begin
      rv[p]  = mm[a[p]];
      rok[p] = mv[a[p]];
    end
    acc = tvalid && mready && resetn;
    if (acc) begin
      if (!mptr[4]) begin
        for (int k = 0; k < 4; k++) begin
          mm[mptr[3:0] + 4'(k)] = tdata[k*PW +: PW];
          mv[mptr[3:0] + 4'(k)] = 1'b1;
        end
        mptr = mptr + 5'd4;
      end else begin
        movf = 1'b1;
      end
      if (tlast) begin
        mptr = '0;
        movf = 1'b0;
      end
    end
    mdone  = acc && tlast;
    mready = !(acc && tlast);
    @(posedge aclk);
    #1;
    if (!resetn) begin
      model_reset();
    end else begin
      for (int p = 0; p < 4; p++) begin
        hv[p][2]  = hv[p][1];
        hok[p][2] = hok[p][1];
        hv[p][1]  = hv[p][0];
        hok[p][1] = hok[p][0];
        hv[p][0]  = rv[p];
        hok[p][0] = rok[p];
      end
    end
    check_all();
  endtask

  task automatic beat(input logic [SW-1:0] d, input bit last);
    tvalid = 1'b1;
    tdata  = d;
    tlast  = last;
    tick();
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = '0;
    for (int p = 0; p < 4; p++) a[p] = '0;
    for (int i = 0; i < 16; i++) begin
      mm[i] = '0;
      mv[i] = 1'b0;
    end
    model_reset();

    tick();
    tick();
    #2 resetn = 1'b1;
    tick();
    chk("ready_after_rst", 32'(tready1), 32'd1);

    for (int b = 0; b < 4; b++)
      beat(pk(4*b, 4*b+1, 4*b+2, 4*b+3), b == 3);
    chk("upload_done", 32'(done1), 32'd1);
    chk("done_tready", 32'(tready1), 32'd0);
    tick();
    chk("done_once", 32'(done1), 32'd0);

    a[0] = 4'd0;
    a[1] = 4'd5;
    a[2] = 4'd10;
    a[3] = 4'd15;
    tick();
    chk("rb1_00", 32'(o1[0]), 32'h0);
    chk("rb1_01", 32'(o1[1]), 32'h5);
    chk("rb1_10", 32'(o1[2]), 32'hA);
    chk("rb1_11", 32'(o1[3]), 32'hF);
    tick();
    tick();
    chk("rb3_00", 32'(o3[0]), 32'h0);
    chk("rb3_01", 32'(o3[1]), 32'h5);
    chk("rb3_10", 32'(o3[2]), 32'hA);
    chk("rb3_11", 32'(o3[3]), 32'hF);

    for (int i = 0; i < 64; i++) begin
      for (int p = 0; p < 4; p++)
        a[p] = 4'((i*3 + p*5) % 16);
      tick();
    end

    beat(pk(16'h1234, 1, 2, 3), 1'b1);
    tick();
    a[0] = 4'd0;
    beat(pk(16'hBEEF, 1, 2, 3), 1'b0);
    chk("rf_old", 32'(o1[0]), 32'h1234);
    tick();
    chk("rf_new", 32'(o1[0]), 32'hBEEF);
    beat(pk(4, 5, 6, 7), 1'b0);
    beat(pk(8, 9, 10, 11), 1'b0);
    beat(pk(12, 13, 14, 15), 1'b1);
    tick();

    for (int b = 0; b < 5; b++)
      beat(pk(16'h100+4*b, 16'h101+4*b, 16'h102+4*b, 16'h103+4*b), 1'b0);
    chk("ovf_set", 32'(ovf1), 32'd1);
    tick();
    chk("ovf_addr0", 32'(o1[0]), 32'h100);
    chk("ovf_hold", 32'(ovf1), 32'd1);
    beat(pk(16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD), 1'b1);
    chk("ovf_clear", 32'(ovf1), 32'd0);
    chk("ovf_done", 32'(done1), 32'd1);
    tick();
    chk("ovf_drop", 32'(o1[0]), 32'h100);

    a[1] = 4'd4;
    tvalid = 1'b1;
    tdata  = pk(16'h200, 16'h201, 16'h202, 16'h203);
    tlast  = 1'b1;
    tick();
    tdata = pk(16'h300, 16'h301, 16'h302, 16'h303);
    tlast = 1'b0;
    tick();
    chk("bp_stall", 32'(tready1), 32'd1);
    tick();
    tdata = pk(16'h310, 16'h311, 16'h312, 16'h313);
    tlast = 1'b1;
    tick();
    tvalid = 1'b0;
    tlast  = 1'b0;
    tick();
    tick();
    chk("bp_addr0", 32'(o1[0]), 32'h300);
    chk("bp_addr4", 32'(o1[1]), 32'h310);

    a[1] = 4'd5;
    beat(pk(16'h400, 16'h401, 16'h402, 16'h403), 1'b0);
    #2 resetn = 1'b0;
    model_reset();
    #1;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("rst_o1_%0d", p), 32'(o1[p]), 32'h0);
      chk($sformatf("rst_o3_%0d", p), 32'(o3[p]), 32'h0);
    end
    chk("rst_tready", 32'(tready1), 32'd0);
    tick();
    tick();
    tick();
    #2 resetn = 1'b1;
    tick();
    beat(pk(16'h500, 16'h501, 16'h502, 16'h503), 1'b1);
    tick();
    tick();
    chk("rst_first_beat", 32'(o1[0]), 32'h500);
    chk("rst_kept", 32'(o1[1]), 32'h311);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
